// File: rtl/nonce_golden_ctrl.sv
// Nonce issue / result alignment stage around the double-SHA256 pipelines.
// Matching results are queued in a small first-word-fall-through golden-nonce FIFO.
module nonce_golden_ctrl #(
  parameter int unsigned LATENCY    = 200,
  parameter logic [31:0] MATCH      = 32'ha41f32e7,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] start_nonce,
  input  logic        run,
  output logic [31:0] nonce_out,
  input  logic [31:0] hash_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] gn_data,
  output logic        gn_valid,
  input  logic        gn_ready,
  output logic        gn_overflow,
  output logic [31:0] checked
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [31:0]        nonce_q, nonce_d;
  logic [31:0]        chk_q, chk_d;
  logic [31:0]        checked_q, checked_d;
  logic [LATENCY-1:0] dl_q, dl_d;
  logic [AW-1:0]      rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic [31:0]        gn_data_q, gn_data_d;
  logic               gn_valid_q, gn_valid_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [31:0]        mem_q [FIFO_DEPTH];

  logic issue, tv, pop, push, push_ok;

  always_comb begin
    state_d   = state_q;
    nonce_d   = nonce_q;
    chk_d     = chk_q;
    checked_d = checked_q;
    dl_d      = dl_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    issue     = 1'b0;
    push      = 1'b0;
    push_ok   = 1'b0;
    tv        = dl_q[LATENCY-1];
    pop       = gn_valid_q & gn_ready;

    // A load discards everything in flight, including this cycle's result and pop.
    if (load) begin
      state_d   = S_RUN;
      nonce_d   = start_nonce;
      chk_d     = start_nonce;
      checked_d = '0;
      dl_d      = '0;
      rd_d      = '0;
      wr_d      = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          issue = run;
          dl_d  = (dl_q << 1) | LATENCY'(issue);
          if (issue) begin
            nonce_d = nonce_q + 32'd1;
            if (nonce_q == '1) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          dl_d = dl_q << 1;
          if (dl_q == '0) state_d = S_DONE;
        end
        default: ;
      endcase

      if (tv) begin
        checked_d = checked_q + 32'd1;
        chk_d     = chk_q + 32'd1;
        push      = (hash_in == MATCH);
      end

      // A pop in the same cycle frees the slot a full FIFO needs for the push.
      push_ok = push & ((cnt_q != FULL_CNT) | pop);
      if (push & ~push_ok) ovf_d = 1'b1;
      if (pop)     rd_d = rd_q + AW'(1);
      if (push_ok) wr_d = wr_q + AW'(1);
      if (push_ok & ~pop)      cnt_d = cnt_q + (AW + 1)'(1);
      else if (~push_ok & pop) cnt_d = cnt_q - (AW + 1)'(1);
    end

    gn_valid_d = (cnt_d != '0);
    if (!gn_valid_d)                gn_data_d = '0;
    else if (push_ok && wr_q == rd_d) gn_data_d = chk_q;
    else                            gn_data_d = mem_q[rd_d];

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      nonce_q    <= '0;
      chk_q      <= '0;
      checked_q  <= '0;
      dl_q       <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      gn_data_q  <= '0;
      gn_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      nonce_q    <= nonce_d;
      chk_q      <= chk_d;
      checked_q  <= checked_d;
      dl_q       <= dl_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      gn_data_q  <= gn_data_d;
      gn_valid_q <= gn_valid_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= chk_q;
  end

  assign nonce_out   = nonce_q;
  assign checked     = checked_q;
  assign gn_data     = gn_data_q;
  assign gn_valid    = gn_valid_q;
  assign gn_overflow = ovf_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_nonce_golden_ctrl.sv
// Scoreboard bench for nonce_golden_ctrl: a transaction-level model predicts the
// golden nonces and status, a negedge monitor compares whatever the DUT presents.
module tb_nonce_golden_ctrl;

  localparam int          LAT     = 4;
  localparam int          DEP     = 4;
  localparam logic [31:0] MATCH_V = 32'ha41f32e7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic        run = 1'b0;
  logic        gn_ready = 1'b0;
  logic [31:0] start_nonce = '0;
  logic [31:0] hash_in = '0;
  logic [31:0] nonce_out, gn_data, checked;
  logic        busy, done, gn_valid, gn_overflow;

  nonce_golden_ctrl #(.LATENCY(LAT), .MATCH(MATCH_V), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .load(load), .start_nonce(start_nonce), .run(run),
    .nonce_out(nonce_out), .hash_in(hash_in), .busy(busy), .done(done),
    .gn_data(gn_data), .gn_valid(gn_valid), .gn_ready(gn_ready),
    .gn_overflow(gn_overflow), .checked(checked)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] n; longint due; } pend_t;

  int          n_checks = 0, n_fail = 0;
  logic [31:0] targets[$];
  logic [31:0] hq[$];
  logic [31:0] exp_q[$];
  pend_t       pend[$];
  longint      cyc_n = 0;
  int          m_phase = 0;  // 0 idle, 1 run, 2 drain, 3 done
  int          m_cnt = 0;
  logic [31:0] m_nonce = '0, m_checked = '0;
  logic        m_ovf = 1'b0;
  int          n_recv = 0;
  logic [31:0] last_recv = '0;

  function automatic bit is_tgt(logic [31:0] v);
    foreach (targets[i]) if (targets[i] === v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endfunction

  // Pipeline stand-in: hash word for the nonce presented LAT cycles earlier.
  always @(negedge clk) begin
    hq.push_back(nonce_out);
    if (hq.size() > LAT) hash_in = is_tgt(hq.pop_front()) ? MATCH_V : 32'd0;
  end

  // Reference model, advanced once per clock edge.
  always @(posedge clk) begin
    bit     popm, acc, empty0;
    longint c;
    c = cyc_n;
    if (reset) begin
      m_phase = 0; m_nonce = '0; m_checked = '0; m_ovf = 1'b0; m_cnt = 0;
      pend.delete(); exp_q.delete();
    end else if (load) begin
      m_phase = 1; m_nonce = start_nonce; m_checked = '0; m_ovf = 1'b0; m_cnt = 0;
      pend.delete(); exp_q.delete();
    end else begin
      empty0 = (pend.size() == 0);
      popm   = (m_cnt > 0) && gn_ready;
      acc    = 1'b0;
      if (pend.size() > 0 && pend[0].due == c) begin
        m_checked++;
        if (is_tgt(pend[0].n)) begin
          if (m_cnt < DEP || popm) begin acc = 1'b1; exp_q.push_back(pend[0].n); end
          else m_ovf = 1'b1;
        end
        void'(pend.pop_front());
      end
      m_cnt = m_cnt + int'(acc) - int'(popm);
      if (m_phase == 1 && run) begin
        pend.push_back('{m_nonce, c + LAT});
        if (m_nonce == 32'hffffffff) m_phase = 2;
        m_nonce++;
      end else if (m_phase == 2 && empty0) begin
        m_phase = 3;
      end
    end
    cyc_n = c + 1;
  end

  // Monitor.
  always @(negedge clk) begin
    if (cyc_n > 0) begin
      chk("nonce_out", nonce_out, m_nonce);
      chk("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
      chk("done", 32'(done), 32'(m_phase == 3));
      chk("checked", checked, m_checked);
      chk("gn_overflow", 32'(gn_overflow), 32'(m_ovf));
      chk("gn_valid", 32'(gn_valid), 32'(m_cnt > 0));
      if (gn_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL gn_data: got %h expected no entry (cycle %0d)", gn_data, cyc_n);
        end else begin
          chk("gn_data", gn_data, exp_q[0]);
        end
        if (gn_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          n_recv++;
          last_recv = gn_data;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [31:0] s);
    start_nonce = s; load = 1'b1; cyc(); load = 1'b0;
  endtask

  initial begin
    int          n_on, w;
    logic [31:0] base;

    cyc(); cyc();
    reset = 1'b0;
    chk("rst_nonce", nonce_out, 32'd0);
    chk("rst_checked", checked, 32'd0);
    chk("rst_gn_data", gn_data, 32'd0);
    chk("rst_flags", {28'd0, busy, done, gn_valid, gn_overflow}, 32'd0);

    // Continuous run from 100, targets 103 and 110.
    targets.delete(); targets.push_back(32'd103); targets.push_back(32'd110);
    gn_ready = 1'b1; n_recv = 0;
    do_load(32'd100);
    chk("s1_first_nonce", nonce_out, 32'd100);
    chk("s1_busy", 32'(busy), 32'd1);
    run = 1'b1; repeat (20) cyc(); run = 1'b0;
    repeat (LAT + 2) cyc();
    chk("s1_recv", n_recv, 32'd2);
    chk("s1_last", last_recv, 32'd110);
    chk("s1_checked", checked, 32'd20);

    // Same, with bubbles 1,0,0,1,0,1.
    n_recv = 0; n_on = 0;
    do_load(32'd100);
    for (int i = 0; i < 48; i++) begin
      run = (i % 6 == 0) || (i % 6 == 3) || (i % 6 == 5);
      if (run) n_on++;
      cyc();
    end
    run = 1'b0;
    repeat (LAT + 2) cyc();
    chk("s2_recv", n_recv, 32'd2);
    chk("s2_last", last_recv, 32'd110);
    chk("s2_checked", checked, 32'(n_on));

    // End of range: drain and done.
    targets.delete(); targets.push_back(32'hffffffff);
    n_recv = 0;
    do_load(32'hfffffffd);
    run = 1'b1;
    w = 0;
    while (done !== 1'b1 && w < 40) begin cyc(); w++; end
    chk("s3_done_reached", 32'(done), 32'd1);
    repeat (3) cyc();
    run = 1'b0;
    chk("s3_checked", checked, 32'd3);
    chk("s3_recv", n_recv, 32'd1);
    chk("s3_last", last_recv, 32'hffffffff);
    chk("s3_nonce_wrapped", nonce_out, 32'd0);

    // FIFO full, overflow, push+pop while full, drain.
    targets.delete();
    for (int i = 0; i < 6; i++) targets.push_back(32'(i));
    gn_ready = 1'b0; n_recv = 0;
    do_load(32'd0);
    run = 1'b1; repeat (5) cyc(); run = 1'b0;
    repeat (LAT + 2) cyc();
    chk("s4_overflow", 32'(gn_overflow), 32'd1);
    chk("s4_valid_full", 32'(gn_valid), 32'd1);
    chk("s4_head", gn_data, 32'd0);
    run = 1'b1; cyc(); run = 1'b0;
    repeat (LAT - 1) cyc();
    gn_ready = 1'b1; cyc(); gn_ready = 1'b0;
    chk("s4_pushpop_valid", 32'(gn_valid), 32'd1);
    chk("s4_pushpop_head", gn_data, 32'd1);
    chk("s4_pushpop_recv", n_recv, 32'd1);
    gn_ready = 1'b1; repeat (6) cyc();
    chk("s4_drain_recv", n_recv, 32'd5);
    chk("s4_drain_last", last_recv, 32'd5);
    chk("s4_drain_empty", 32'(gn_valid), 32'd0);

    // Reload while 50 is still in flight.
    targets.delete(); targets.push_back(32'd50);
    n_recv = 0;
    do_load(32'd48);
    run = 1'b1; repeat (4) cyc();
    start_nonce = 32'd1000; load = 1'b1; cyc(); load = 1'b0;
    repeat (10) cyc(); run = 1'b0;
    repeat (LAT + 2) cyc();
    chk("s5_recv", n_recv, 32'd0);
    chk("s5_overflow", 32'(gn_overflow), 32'd0);
    chk("s5_checked", checked, 32'd10);

    // Reset mid-run with two entries queued.
    targets.delete(); targets.push_back(32'd2000); targets.push_back(32'd2001);
    gn_ready = 1'b0;
    do_load(32'd2000);
    run = 1'b1; repeat (LAT + 3) cyc();
    chk("s6_two_queued", 32'(gn_valid), 32'd1);
    reset = 1'b1; cyc(); reset = 1'b0; run = 1'b0;
    chk("s6_nonce", nonce_out, 32'd0);
    chk("s6_checked", checked, 32'd0);
    chk("s6_gn_data", gn_data, 32'd0);
    chk("s6_flags", {28'd0, busy, done, gn_valid, gn_overflow}, 32'd0);

    // Randomised runs; the second starts near the top of the range.
    for (int r = 0; r < 2; r++) begin
      base = (r == 0) ? $urandom : (32'hffffffff - 32'($urandom_range(40, 80)));
      targets.delete();
      for (int k = 0; k < 6; k++) targets.push_back(base + 32'($urandom_range(0, 90)));
      gn_ready = 1'b1;
      do_load(base);
      for (int i = 0; i < 150; i++) begin
        run      = ($urandom_range(0, 3) != 0);
        gn_ready = ($urandom_range(0, 2) != 0);
        cyc();
      end
      run = 1'b0; gn_ready = 1'b1;
      repeat (LAT + 10) cyc();
      chk("rand_all_delivered", 32'(exp_q.size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
